// File: rtl/uart_istek_hakemi.sv
// Two-port round-robin arbiter in front of the UART request/response port.
// One transaction outstanding at a time; a local ACK is issued on UART timeout.

`ifndef ADRES_BIT
`define ADRES_BIT 32
`endif
`ifndef VERI_BIT
`define VERI_BIT 32
`endif
`ifndef TL_A_BITS
`define TL_A_BITS 16
`endif
`ifndef TL_D_BITS
`define TL_D_BITS 8
`endif
`ifndef TL_D_OP_MSB
`define TL_D_OP_MSB 2
`endif
`ifndef TL_D_OP_LSB
`define TL_D_OP_LSB 0
`endif
`ifndef TL_OP_ACK
`define TL_OP_ACK 3'd1
`endif

module uart_istek_hakemi #(
  parameter int ZAMAN_ASIMI = 1024,
  parameter int SAYAC_BIT   = 11
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [`ADRES_BIT-1:0] m0_adres_i,
  input  logic [`VERI_BIT-1:0]  m0_veri_i,
  input  logic [`TL_A_BITS-1:0] m0_tilefields_i,
  input  logic                  m0_gecerli_i,
  output logic                  m0_hazir_o,
  output logic [`VERI_BIT-1:0]  m0_veri_o,
  output logic [`TL_D_BITS-1:0] m0_tilefields_o,
  output logic                  m0_gecerli_o,
  input  logic                  m0_hazir_i,
  input  logic [`ADRES_BIT-1:0] m1_adres_i,
  input  logic [`VERI_BIT-1:0]  m1_veri_i,
  input  logic [`TL_A_BITS-1:0] m1_tilefields_i,
  input  logic                  m1_gecerli_i,
  output logic                  m1_hazir_o,
  output logic [`VERI_BIT-1:0]  m1_veri_o,
  output logic [`TL_D_BITS-1:0] m1_tilefields_o,
  output logic                  m1_gecerli_o,
  input  logic                  m1_hazir_i,
  output logic [`ADRES_BIT-1:0] cek_adres_o,
  output logic [`VERI_BIT-1:0]  cek_veri_o,
  output logic [`TL_A_BITS-1:0] cek_tilefields_o,
  output logic                  cek_gecerli_o,
  input  logic                  cek_hazir_i,
  input  logic [`VERI_BIT-1:0]  uart_veri_i,
  input  logic [`TL_D_BITS-1:0] uart_tilefields_i,
  input  logic                  uart_gecerli_i,
  output logic                  uart_hazir_o,
  output logic                  zaman_asimi_o
);

  typedef enum logic [1:0] {BOSTA, ISTEK, YANIT_BEKLE, YEREL_YANIT} durum_t;

  durum_t                durum_q, durum_d;
  logic                  oncelik_q, oncelik_d;
  logic                  sahip_q, sahip_d;
  logic [SAYAC_BIT-1:0]  sayac_q, sayac_d;
  logic [`ADRES_BIT-1:0] adres_q, adres_d;
  logic [`VERI_BIT-1:0]  veri_q, veri_d;
  logic [`TL_A_BITS-1:0] tl_q, tl_d;

  logic                  kazanan;
  logic                  sahip_hazir;
  logic                  yanit_gecerli;
  logic [`VERI_BIT-1:0]  yanit_veri;
  logic [`TL_D_BITS-1:0] yanit_tl;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q   <= BOSTA;
      oncelik_q <= 1'b0;
      sahip_q   <= 1'b0;
      sayac_q   <= '0;
      adres_q   <= '0;
      veri_q    <= '0;
      tl_q      <= '0;
    end else begin
      durum_q   <= durum_d;
      oncelik_q <= oncelik_d;
      sahip_q   <= sahip_d;
      sayac_q   <= sayac_d;
      adres_q   <= adres_d;
      veri_q    <= veri_d;
      tl_q      <= tl_d;
    end
  end

  // Grant logic is gated by reset so outputs take their idle values immediately.
  always_comb begin
    durum_d       = durum_q;
    oncelik_d     = oncelik_q;
    sahip_d       = sahip_q;
    sayac_d       = sayac_q;
    adres_d       = adres_q;
    veri_d        = veri_q;
    tl_d          = tl_q;
    m0_hazir_o    = 1'b0;
    m1_hazir_o    = 1'b0;
    uart_hazir_o  = 1'b1;
    zaman_asimi_o = 1'b0;
    yanit_gecerli = 1'b0;
    yanit_veri    = '0;
    yanit_tl      = '0;
    kazanan       = (m0_gecerli_i && m1_gecerli_i) ? oncelik_q : m1_gecerli_i;
    sahip_hazir   = sahip_q ? m1_hazir_i : m0_hazir_i;
    if (!rst_i) begin
      case (durum_q)
        BOSTA: begin
          if (m0_gecerli_i || m1_gecerli_i) begin
            m0_hazir_o = ~kazanan;
            m1_hazir_o = kazanan;
            sahip_d    = kazanan;
            oncelik_d  = ~oncelik_q;
            adres_d    = kazanan ? m1_adres_i      : m0_adres_i;
            veri_d     = kazanan ? m1_veri_i       : m0_veri_i;
            tl_d       = kazanan ? m1_tilefields_i : m0_tilefields_i;
            durum_d    = ISTEK;
          end
        end
        ISTEK: begin
          if (cek_hazir_i) begin
            sayac_d = '0;
            durum_d = YANIT_BEKLE;
          end
        end
        YANIT_BEKLE: begin
          uart_hazir_o  = sahip_hazir;
          yanit_gecerli = uart_gecerli_i;
          yanit_veri    = uart_veri_i;
          yanit_tl      = uart_tilefields_i;
          // A completion in the last counted cycle wins over the timeout.
          if (uart_gecerli_i && sahip_hazir) begin
            durum_d = BOSTA;
          end else if (sayac_q == SAYAC_BIT'(ZAMAN_ASIMI - 1)) begin
            zaman_asimi_o = 1'b1;
            durum_d       = YEREL_YANIT;
          end else begin
            sayac_d = sayac_q + 1'b1;
          end
        end
        YEREL_YANIT: begin
          yanit_gecerli = 1'b1;
          yanit_tl[`TL_D_OP_MSB:`TL_D_OP_LSB] = `TL_OP_ACK;
          if (sahip_hazir) begin
            durum_d = BOSTA;
          end
        end
        default: durum_d = BOSTA;
      endcase
    end
  end

  assign cek_gecerli_o    = (durum_q == ISTEK);
  assign cek_adres_o      = adres_q;
  assign cek_veri_o       = veri_q;
  assign cek_tilefields_o = tl_q;

  assign m0_gecerli_o    = yanit_gecerli & ~sahip_q;
  assign m1_gecerli_o    = yanit_gecerli & sahip_q;
  assign m0_veri_o       = sahip_q ? '0 : yanit_veri;
  assign m1_veri_o       = sahip_q ? yanit_veri : '0;
  assign m0_tilefields_o = sahip_q ? '0 : yanit_tl;
  assign m1_tilefields_o = sahip_q ? yanit_tl : '0;

endmodule

// File: tb/tb_uart_istek_hakemi.sv
// Bench for the UART request arbiter: directed transactions with literal
// expectations, plus a transaction-level model compared on every cycle.
module tb_uart_istek_hakemi;

   localparam int TIMEOUT = 8;

   logic clock;
   logic reset;

   logic [31:0] m0Adres, m1Adres, m0Veri, m1Veri, uartVeri;
   logic [15:0] m0Tl, m1Tl;
   logic [7:0]  uartTl;
   logic        m0Gecerli, m1Gecerli, m0HazirIn, m1HazirIn, cekHazir, uartGecerli;

   logic        m0HazirOut, m1HazirOut, m0GecerliOut, m1GecerliOut;
   logic [31:0] m0VeriOut, m1VeriOut, cekAdres, cekVeri;
   logic [7:0]  m0TlOut, m1TlOut;
   logic [15:0] cekTl;
   logic        cekGecerli, uartHazir, zamanAsimi;

   int errors = 0;
   int checks = 0;

   uart_istek_hakemi #(.ZAMAN_ASIMI(TIMEOUT), .SAYAC_BIT(4)) dut (
      .clk_i(clock), .rst_i(reset),
      .m0_adres_i(m0Adres), .m0_veri_i(m0Veri), .m0_tilefields_i(m0Tl),
      .m0_gecerli_i(m0Gecerli), .m0_hazir_o(m0HazirOut), .m0_veri_o(m0VeriOut),
      .m0_tilefields_o(m0TlOut), .m0_gecerli_o(m0GecerliOut), .m0_hazir_i(m0HazirIn),
      .m1_adres_i(m1Adres), .m1_veri_i(m1Veri), .m1_tilefields_i(m1Tl),
      .m1_gecerli_i(m1Gecerli), .m1_hazir_o(m1HazirOut), .m1_veri_o(m1VeriOut),
      .m1_tilefields_o(m1TlOut), .m1_gecerli_o(m1GecerliOut), .m1_hazir_i(m1HazirIn),
      .cek_adres_o(cekAdres), .cek_veri_o(cekVeri), .cek_tilefields_o(cekTl),
      .cek_gecerli_o(cekGecerli), .cek_hazir_i(cekHazir),
      .uart_veri_i(uartVeri), .uart_tilefields_i(uartTl), .uart_gecerli_i(uartGecerli),
      .uart_hazir_o(uartHazir), .zaman_asimi_o(zamanAsimi)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case the directed sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advances to just after the next rising edge and drives a new input set;
   // returns one time unit later so callers can check combinational outputs.
   task automatic applyStimulus(input bit v0, input logic [31:0] d0, input bit v1,
                                input logic [31:0] d1, input bit ch, input bit uv,
                                input logic [31:0] ud, input bit h0, input bit h1);
      @(posedge clock);
      #1;
      m0Gecerli   = v0;
      m0Veri      = d0;
      m0Adres     = 32'h4000_0000 + d0;
      m1Gecerli   = v1;
      m1Veri      = d1;
      m1Adres     = 32'h5000_0000 + d1;
      cekHazir    = ch;
      uartGecerli = uv;
      uartVeri    = ud;
      m0HazirIn   = h0;
      m1HazirIn   = h1;
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
   endtask

   task automatic pulseReset();
      @(posedge clock);
      #1;
      reset = 1'b1;
      m0Gecerli = 0; m1Gecerli = 0; cekHazir = 0; uartGecerli = 0;
      #2;
      reset = 1'b0;
   endtask

   // Model state: transaction phase (0 idle, 1 request to UART, 2 awaiting
   // the UART, 3 local ACK), owner, favoured port, cycles waited, and the
   // captured request. "nx*" is the state the model will hold after the edge.
   int          mdlPhase, nxPhase;
   logic        mdlOwner, nxOwner, mdlFavor, nxFavor;
   int          mdlWaited, nxWaited;
   logic [31:0] mdlAdres, nxAdres, mdlVeri, nxVeri;
   logic [15:0] mdlTl, nxTl;

   // Commit the model's next state on each rising edge; reset clears it at once.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mdlPhase <= 0; mdlOwner <= 0; mdlFavor <= 0; mdlWaited <= 0;
         mdlAdres <= 0; mdlVeri <= 0; mdlTl <= 0;
      end else begin
         mdlPhase <= nxPhase; mdlOwner <= nxOwner; mdlFavor <= nxFavor;
         mdlWaited <= nxWaited; mdlAdres <= nxAdres; mdlVeri <= nxVeri; mdlTl <= nxTl;
      end
   end

   // On each falling edge work out what every output must be from the
   // arbitration rules, compare against the DUT, and plan the next state.
   always @(negedge clock) begin
      logic       eHz [2];
      logic       eV [2];
      logic [31:0] eD [2];
      logic [7:0]  eT [2];
      logic       eUart, eTo, eCek, ownReady, win;
      eHz[0] = 0; eHz[1] = 0; eV[0] = 0; eV[1] = 0;
      eD[0] = 0; eD[1] = 0; eT[0] = 0; eT[1] = 0;
      eUart = 1; eTo = 0; eCek = 0;
      nxPhase = mdlPhase; nxOwner = mdlOwner; nxFavor = mdlFavor;
      nxWaited = mdlWaited; nxAdres = mdlAdres; nxVeri = mdlVeri; nxTl = mdlTl;
      ownReady = mdlOwner ? m1HazirIn : m0HazirIn;
      if (!reset) begin
         if (mdlPhase == 0 && (m0Gecerli || m1Gecerli)) begin
            win = (m0Gecerli && m1Gecerli) ? mdlFavor : m1Gecerli;
            eHz[win] = 1;
            nxOwner = win;
            nxFavor = ~mdlFavor;
            nxAdres = win ? m1Adres : m0Adres;
            nxVeri  = win ? m1Veri : m0Veri;
            nxTl    = win ? m1Tl : m0Tl;
            nxPhase = 1;
         end else if (mdlPhase == 1) begin
            eCek = 1;
            if (cekHazir) begin
               nxPhase = 2;
               nxWaited = 1;
            end
         end else if (mdlPhase == 2) begin
            eUart = ownReady;
            eV[mdlOwner] = uartGecerli;
            eD[mdlOwner] = uartVeri;
            eT[mdlOwner] = uartTl;
            if (uartGecerli && ownReady) nxPhase = 0;
            else if (mdlWaited == TIMEOUT) begin
               eTo = 1;
               nxPhase = 3;
            end else nxWaited = mdlWaited + 1;
         end else if (mdlPhase == 3) begin
            eV[mdlOwner] = 1;
            eT[mdlOwner] = 8'h01;
            if (ownReady) nxPhase = 0;
         end
      end
      checkOutput("mdl m0_hazir_o", m0HazirOut, eHz[0]);
      checkOutput("mdl m1_hazir_o", m1HazirOut, eHz[1]);
      checkOutput("mdl m0_gecerli_o", m0GecerliOut, eV[0]);
      checkOutput("mdl m1_gecerli_o", m1GecerliOut, eV[1]);
      checkOutput("mdl m0_veri_o", m0VeriOut, eD[0]);
      checkOutput("mdl m1_veri_o", m1VeriOut, eD[1]);
      checkOutput("mdl m0_tilefields_o", m0TlOut, eT[0]);
      checkOutput("mdl m1_tilefields_o", m1TlOut, eT[1]);
      checkOutput("mdl cek_gecerli_o", cekGecerli, eCek);
      checkOutput("mdl cek_adres_o", cekAdres, mdlAdres);
      checkOutput("mdl cek_veri_o", cekVeri, mdlVeri);
      checkOutput("mdl cek_tilefields_o", cekTl, mdlTl);
      checkOutput("mdl uart_hazir_o", uartHazir, eUart);
      checkOutput("mdl zaman_asimi_o", zamanAsimi, eTo);
   end

   // Directed sequence with hand-computed literal expectations.
   initial begin
      int n0, n1, w;
      logic [31:0] d;
      reset = 1; m0Gecerli = 0; m1Gecerli = 0; m0Veri = 0; m1Veri = 0;
      m0Adres = 0; m1Adres = 0; m0Tl = 16'h00A0; m1Tl = 16'h00B1;
      m0HazirIn = 1; m1HazirIn = 1; cekHazir = 0; uartGecerli = 0;
      uartVeri = 0; uartTl = 8'h0C;
      #2;
      checkOutput("reset m0_hazir_o", m0HazirOut, 0);
      checkOutput("reset cek_gecerli_o", cekGecerli, 0);
      checkOutput("reset cek_adres_o", cekAdres, 0);
      checkOutput("reset uart_hazir_o", uartHazir, 1);
      checkOutput("reset zaman_asimi_o", zamanAsimi, 0);
      @(posedge clock);
      #1 reset = 0;

      $display("[TB] port 0 write with immediate UART ack");
      applyStimulus(1, 32'h11, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("t0 m0_hazir_o", m0HazirOut, 1);
      checkOutput("t0 m1_hazir_o", m1HazirOut, 0);
      applyStimulus(0, 32'h11, 0, 0, 1, 0, 0, 1, 1);
      checkOutput("t1 cek_gecerli_o", cekGecerli, 1);
      checkOutput("t1 cek_adres_o", cekAdres, 32'h4000_0011);
      checkOutput("t1 cek_veri_o", cekVeri, 32'h11);
      checkOutput("t1 cek_tilefields_o", cekTl, 16'h00A0);
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h55, 1, 1);
      checkOutput("t2 m0_gecerli_o", m0GecerliOut, 1);
      checkOutput("t2 m0_veri_o", m0VeriOut, 32'h55);
      checkOutput("t2 m0_tilefields_o", m0TlOut, 8'h0C);
      checkOutput("t2 m1_gecerli_o", m1GecerliOut, 0);
      idle();
      checkOutput("t3 m0_gecerli_o", m0GecerliOut, 0);

      $display("[TB] both ports requesting continuously");
      pulseReset();
      n0 = 0; n1 = 0;
      for (int i = 0; i < 4; i++) begin
         w = i % 2;
         applyStimulus(1, 32'hA0 + n0, 1, 32'hB0 + n1, 0, 0, 0, 1, 1);
         checkOutput("rr m0_hazir_o", m0HazirOut, (w == 0));
         checkOutput("rr m1_hazir_o", m1HazirOut, (w == 1));
         d = (w == 1) ? 32'hB0 + n1 : 32'hA0 + n0;
         applyStimulus(1, 32'hA0 + n0, 1, 32'hB0 + n1, 1, 0, 0, 1, 1);
         checkOutput("rr cek_veri_o", cekVeri, d);
         applyStimulus(1, 32'hA0 + n0, 1, 32'hB0 + n1, 0, 1, d ^ 32'hFFFF_0000, 1, 1);
         checkOutput("rr owner gecerli", (w == 1) ? m1GecerliOut : m0GecerliOut, 1);
         checkOutput("rr owner veri", (w == 1) ? m1VeriOut : m0VeriOut, d ^ 32'hFFFF_0000);
         checkOutput("rr other gecerli", (w == 1) ? m0GecerliOut : m1GecerliOut, 0);
         if (w == 1) n1++; else n0++;
      end

      $display("[TB] port 1 read with response back-pressure");
      applyStimulus(0, 0, 1, 32'h33, 0, 0, 0, 1, 1);
      checkOutput("bp m1_hazir_o", m1HazirOut, 1);
      checkOutput("bp m0_hazir_o", m0HazirOut, 0);
      applyStimulus(0, 0, 0, 32'h33, 1, 0, 0, 1, 1);
      checkOutput("bp cek_adres_o", cekAdres, 32'h5000_0033);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 1, 32'hA5, 1, 0);
         checkOutput("bp m1_gecerli_o held", m1GecerliOut, 1);
         checkOutput("bp m1_veri_o", m1VeriOut, 32'hA5);
         checkOutput("bp uart_hazir_o low", uartHazir, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 1, 32'hA5, 1, 1);
      checkOutput("bp uart_hazir_o high", uartHazir, 1);
      checkOutput("bp m1_gecerli_o final", m1GecerliOut, 1);
      idle();
      checkOutput("bp m1_gecerli_o done", m1GecerliOut, 0);

      $display("[TB] UART never answers");
      applyStimulus(1, 32'h44, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("to m0_hazir_o", m0HazirOut, 1);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 1);
      for (int k = 1; k < TIMEOUT; k++) begin
         idle();
         checkOutput("to early pulse", zamanAsimi, 0);
      end
      idle();
      checkOutput("to zaman_asimi_o", zamanAsimi, 1);
      checkOutput("to m0_gecerli_o before ack", m0GecerliOut, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("to ack gecerli", m0GecerliOut, 1);
      checkOutput("to ack veri", m0VeriOut, 0);
      checkOutput("to ack tilefields", m0TlOut, 8'h01);
      checkOutput("to pulse once", zamanAsimi, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("to ack taken", m0GecerliOut, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h77, 1, 1);
      checkOutput("late uart_hazir_o", uartHazir, 1);
      checkOutput("late m0_gecerli_o", m0GecerliOut, 0);
      checkOutput("late m1_gecerli_o", m1GecerliOut, 0);

      $display("[TB] response in the last counted cycle");
      applyStimulus(1, 32'h66, 0, 0, 0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 1);
      for (int k = 1; k < TIMEOUT; k++) idle();
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h88, 1, 1);
      checkOutput("edge no pulse", zamanAsimi, 0);
      checkOutput("edge m0_veri_o", m0VeriOut, 32'h88);
      idle();
      checkOutput("edge no local ack", m0GecerliOut, 0);

      $display("[TB] reset while awaiting the UART");
      applyStimulus(1, 32'h22, 0, 0, 0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h99, 0, 1);
      checkOutput("rst pre m0_gecerli_o", m0GecerliOut, 1);
      #1 reset = 1;
      #1;
      checkOutput("rst m0_gecerli_o", m0GecerliOut, 0);
      checkOutput("rst m0_veri_o", m0VeriOut, 0);
      checkOutput("rst uart_hazir_o", uartHazir, 1);
      checkOutput("rst cek_adres_o", cekAdres, 0);
      @(posedge clock);
      #1;
      reset = 0; uartGecerli = 0; m0HazirIn = 1;
      applyStimulus(0, 0, 1, 32'h12, 0, 0, 0, 1, 1);
      checkOutput("post m1_hazir_o", m1HazirOut, 1);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h13, 1, 1);
      checkOutput("post m1_gecerli_o", m1GecerliOut, 1);
      applyStimulus(1, 32'h21, 1, 32'h14, 0, 0, 0, 1, 1);
      checkOutput("post flip m1_hazir_o", m1HazirOut, 1);
      checkOutput("post flip m0_hazir_o", m0HazirOut, 0);
      applyStimulus(1, 32'h21, 0, 0, 1, 0, 0, 1, 1);
      checkOutput("post cek_veri_o", cekVeri, 32'h14);
      applyStimulus(1, 32'h21, 0, 0, 0, 1, 32'h15, 1, 1);
      checkOutput("post m1 response", m1VeriOut, 32'h15);
      idle();
      idle();

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_istek_hakemi.md
# uart_istek_hakemi

Two-port request arbiter placed in front of the UART controller's request/response port. It lets the core data path (port 0) and the debug/loader path (port 1) share the single UART register interface. It grants one requester at a time with round-robin priority and keeps exactly one transaction outstanding. It routes the response back to the owner and synthesizes a local response if the UART does not answer within a timeout.

## Interface
- ZAMAN_ASIMI, 1024: cycles to wait in YANIT_BEKLE before a local timeout response is issued (min 2).
- SAYAC_BIT, 11: counter width; must satisfy 2^SAYAC_BIT > ZAMAN_ASIMI.
- clk_i  in  1  single clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- mN_adres_i  in  `ADRES_BIT  request address, port N (N = 0, 1).
- mN_veri_i  in  `VERI_BIT  write data, port N.
- mN_tilefields_i  in  `TL_A_BITS  A-channel fields, port N.
- mN_gecerli_i  in  1  request valid, port N.
- mN_hazir_o  out  1  request accepted, port N.
- mN_veri_o  out  `VERI_BIT  response data, port N.
- mN_tilefields_o  out  `TL_D_BITS  D-channel fields, port N.
- mN_gecerli_o  out  1  response valid, port N.
- mN_hazir_i  in  1  port N ready for response.
- cek_adres_o / cek_veri_o / cek_tilefields_o  out  `ADRES_BIT / `VERI_BIT / `TL_A_BITS  registered request to the UART.
- cek_gecerli_o  out  1  request valid to the UART.
- cek_hazir_i  in  1  UART accepts request.
- uart_veri_i / uart_tilefields_i  in  `VERI_BIT / `TL_D_BITS  UART response.
- uart_gecerli_i  in  1  UART response valid.
- uart_hazir_o  out  1  arbiter ready for UART response.
- zaman_asimi_o  out  1  one-cycle pulse when a timeout response is generated.

## Operation
- States: BOSTA, ISTEK, YANIT_BEKLE, YEREL_YANIT.
- BOSTA:
  - If any mN_gecerli_i is high, grant per priority register `oncelik` (0 favors port 0).
  - Assert the winner's mN_hazir_o in the same cycle.
  - Capture its adres/veri/tilefields into the request registers and set `sahip` = N.
  - Flip `oncelik` to the other port. Go to ISTEK.
  - The loser's mN_hazir_o stays low.
- ISTEK: cek_gecerli_o = 1 with the captured fields held stable. When cek_hazir_i = 1, go to YANIT_BEKLE and clear the counter.
- YANIT_BEKLE:
  - uart_hazir_o = m[sahip]_hazir_i.
  - m[sahip]_gecerli_o, _veri_o and _tilefields_o pass through uart_* combinationally.
  - When uart_gecerli_i and m[sahip]_hazir_i are both high, go to BOSTA.
  - Otherwise the counter increments.
  - When the counter equals ZAMAN_ASIMI-1 with no completion, go to YEREL_YANIT and pulse zaman_asimi_o.
- YEREL_YANIT:
  - m[sahip]_gecerli_o = 1, veri = 0, tilefields = 0 except TL_D_OP = `TL_OP_ACK.
  - Stays until m[sahip]_hazir_i, then go to BOSTA.
- uart_hazir_o = 1 in BOSTA, ISTEK and YEREL_YANIT. Late or stray UART responses are drained and discarded.
- The non-owner port's mN_gecerli_o is always 0. Response outputs are 0 when not driven.

## Timing
- Reset (async, immediate):
  - durum = BOSTA, oncelik = 0, sahip = 0, counter = 0.
  - All mN_hazir_o, mN_gecerli_o, cek_gecerli_o and zaman_asimi_o = 0.
  - All data/field outputs = 0.
  - uart_hazir_o = 1.
- Reset mid-transaction abandons it. No response is delivered.
- Grant-to-UART latency: request accepted in cycle t, cek_gecerli_o high from t+1.
- Minimum transaction: 3 cycles (accept, UART handshake, response). Next grant is possible in the cycle after response completion.
- Simultaneous requests: the port favored by oncelik wins. Back-to-back simultaneous requests alternate 0,1,0,1.
- A single active requester is granted every transaction regardless of oncelik. oncelik still flips after each grant.
- A response arriving in the same cycle the counter hits ZAMAN_ASIMI-1 completes normally. No timeout pulse.
- Requesters must hold mN_* request fields until mN_hazir_o.

## Test plan
- Port 0 write, UART acks immediately: cek_gecerli_o at t+1, response to m0 only at t+2, m1_gecerli_o = 0 throughout.
- Both ports request continuously, 4 transactions: grants in order m0, m1, m0, m1. Each response returns to its originator with the matching veri.
- Port 1 read, UART responds 0x0000_00A5 while m1_hazir_i is low for 3 cycles: m1_gecerli_o is held and uart_hazir_o stays low. Completes on the cycle m1_hazir_i rises.
- UART never responds (ZAMAN_ASIMI = 8): zaman_asimi_o pulses 8 cycles after the UART handshake. m0 receives a TL_OP_ACK with veri 0.
- Late UART response after that timeout: consumed with uart_hazir_o = 1, no mN_gecerli_o assertion.
- rst_i asserted in YANIT_BEKLE: all outputs reach their reset values without a clock edge. After release, a new m1 request is granted first because oncelik = 0 and only m1 is requesting.
